// File: rtl/commit_monitor.sv
// Run-control and performance monitor behind ROB commit, with a committed-PC trace FIFO.
// Define COMMIT_MONITOR_STALL_EN to add the stall_count output.
module commit_monitor #(
  parameter int PC_W          = 9,
  parameter int ROB_CNT_W     = 5,
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 10,
  parameter int MAX_CYCLES    = 100000,
  parameter int TRACE_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_valid,
  input  logic [PC_W-1:0]      commit_pc,
  input  logic [31:0]          fetch_instr,
  input  logic                 decode_valid,
  input  logic                 rename_valid,
  input  logic                 dispatch_valid,
  input  logic [ROB_CNT_W-1:0] rob_count,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     commit_count,
  output logic [CNT_W-1:0]     done_cycle,
  output logic                 done,
  output logic                 timeout,
`ifdef COMMIT_MONITOR_STALL_EN
  output logic [CNT_W-1:0]     stall_count,
`endif
  output logic                 trace_valid,
  output logic [PC_W-1:0]      trace_pc,
  input  logic                 trace_ready,
  output logic [7:0]           trace_drop
);

  localparam int               SW          = $clog2(SETTLE_CYCLES + 1);
  localparam int               AW          = $clog2(TRACE_DEPTH);
  localparam logic [31:0]      NOP_INSTR   = 32'h0000_0013;
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_SETTLE, ST_DONE, ST_TIMEOUT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  commit_q, commit_d;
  logic [CNT_W-1:0]  done_cycle_q, done_cycle_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              quiet;
  logic              active;

  assign quiet  = (fetch_instr == NOP_INSTR) & ~decode_valid & ~rename_valid &
                  ~dispatch_valid & (rob_count == '0);
  assign active = (state_q == ST_RUN) || (state_q == ST_SETTLE);

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    commit_d     = commit_q;
    done_cycle_d = done_cycle_q;
    settle_d     = settle_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    if (active) begin
      if (~&cycle_q) cycle_d = cycle_q + CNT_W'(1);
      if (commit_valid && ~&commit_q) commit_d = commit_q + CNT_W'(1);
      // Timeout wins over any quiet-driven transition in the same cycle.
      if (cycle_q == MAX_LAST) begin
        state_d   = ST_TIMEOUT;
        timeout_d = 1'b1;
      end else if (state_q == ST_RUN) begin
        if (quiet) begin
          done_cycle_d = cycle_q;
          if (SETTLE_CYCLES == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_SETTLE;
            settle_d = SW'(1);
          end
        end
      end else begin
        if (!quiet) begin
          state_d  = ST_RUN;
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cycle_q      <= '0;
      commit_q     <= '0;
      done_cycle_q <= '0;
      settle_q     <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      commit_q     <= commit_d;
      done_cycle_q <= done_cycle_d;
      settle_q     <= settle_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign cycle_count  = cycle_q;
  assign commit_count = commit_q;
  assign done_cycle   = done_cycle_q;
  assign done         = done_q;
  assign timeout      = timeout_q;

`ifdef COMMIT_MONITOR_STALL_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (active && (rob_count != '0) && !commit_valid && ~&stall_q)
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

  // Trace FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [PC_W-1:0] mem_q [TRACE_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            trace_valid_q, trace_valid_d;
  logic [PC_W-1:0] trace_pc_q, trace_pc_d;
  logic [7:0]      drop_q, drop_d;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            drop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = trace_valid_q & trace_ready;
  assign push_ok = commit_valid & (~full | pop);
  assign drop    = commit_valid & full & ~pop;

  always_comb begin
    wr_ptr_d      = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d      = rd_ptr_q + (AW+1)'(pop);
    trace_valid_d = (wr_ptr_d != rd_ptr_d);
    // Registered head read; bypass the write when the new entry becomes the head.
    if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
      trace_pc_d = commit_pc;
    else
      trace_pc_d = mem_q[rd_ptr_d[AW-1:0]];
    drop_d = drop_q;
    if (drop && ~&drop_q) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= commit_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      drop_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      drop_q        <= drop_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_drop  = drop_q;

endmodule
